// File: rtl/pattern_videogen_if.sv
// Video output bundle of the test-pattern generator: pixel data, syncs,
// data enable, pixel clock and frame marker, as seen by a display sink.
interface pattern_videogen_if;
  logic [7:0] R_out;
  logic [7:0] G_out;
  logic [7:0] B_out;
  logic       HSYNC_out;
  logic       VSYNC_out;
  logic       ENABLE_out;
  logic       PCLK_out;
  logic       frame_start;

  modport master (
    output R_out, G_out, B_out, HSYNC_out, VSYNC_out, ENABLE_out, PCLK_out, frame_start
  );

  modport slave (
    input R_out, G_out, B_out, HSYNC_out, VSYNC_out, ENABLE_out, PCLK_out, frame_start
  );
endinterface

// File: rtl/pattern_videogen.sv
// Video timing generator with selectable grey test patterns (gradient, noise,
// latency boxes, bar ramp). All outputs registered one cycle after h/v count.
module pattern_videogen #(
  parameter int          H_SYNCLEN   = 62,
  parameter int          H_BACKPORCH = 60,
  parameter int          H_ACTIVE    = 720,
  parameter int          H_TOTAL     = 858,
  parameter int          V_SYNCLEN   = 6,
  parameter int          V_BACKPORCH = 30,
  parameter int          V_ACTIVE    = 480,
  parameter int          V_TOTAL     = 525,
  parameter int          CNT_W       = 11,
  parameter bit          SYNC_POL    = 1'b0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          BOX_WDIV    = 8,
  parameter int          BOX_HDIV    = 8
) (
  input  logic                clk27,
  input  logic                reset,
  input  logic [2:0]          mode,
  input  logic [3:0]          scroll_step,
  pattern_videogen_if.master  vid
);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [CNT_W+2:0] wide_t;

  typedef enum logic [2:0] {
    MODE_BLACK        = 3'd0,
    MODE_GRADIENT     = 3'd1,
    MODE_NOISE_STATIC = 3'd2,
    MODE_NOISE_SCROLL = 3'd3,
    MODE_BOX_TL       = 3'd4,
    MODE_BOX_CENTRE   = 3'd5,
    MODE_BOX_BR       = 3'd6,
    MODE_RAMP         = 3'd7
  } mode_e;

  localparam int X_START = H_SYNCLEN + H_BACKPORCH;
  localparam int Y_START = V_SYNCLEN + V_BACKPORCH;
  localparam int BOX_W   = H_ACTIVE / BOX_WDIV;
  localparam int BOX_H   = V_ACTIVE / BOX_HDIV;

  localparam cnt_t BOX_X_MID = cnt_t'((H_ACTIVE - BOX_W) / 2);
  localparam cnt_t BOX_Y_MID = cnt_t'((V_ACTIVE - BOX_H) / 2);
  localparam cnt_t BOX_X_END = cnt_t'(H_ACTIVE - BOX_W);
  localparam cnt_t BOX_Y_END = cnt_t'(V_ACTIVE - BOX_H);

  // The all-ones word is the XNOR lockup state; it must never enter either LFSR.
  localparam logic [15:0] SEED = (LFSR_SEED == 16'hFFFF) ? 16'h0000 : LFSR_SEED;

  // Fibonacci XNOR LFSR, taps 16,15,13,4.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ~(s[15] ^ s[14] ^ s[12] ^ s[3])};
  endfunction

  function automatic logic in_box(input cnt_t x, input cnt_t y, input cnt_t x0, input cnt_t y0);
    return (x >= x0) && (x < x0 + cnt_t'(BOX_W)) &&
           (y >= y0) && (y < y0 + cnt_t'(BOX_H));
  endfunction

  cnt_t        h_cnt;
  cnt_t        v_cnt;
  mode_e       mode_q;
  logic [3:0]  step_q;
  cnt_t        scroll_off;
  logic [15:0] frame_lfsr;
  logic [15:0] pixel_lfsr;

  logic        h_last;
  logic        v_last;
  logic        frame_origin;
  logic        active;
  cnt_t        xpos;
  cnt_t        ypos;
  wide_t       x8;
  logic [2:0]  bar;
  logic [7:0]  pix;

  always_comb begin
    h_last       = (h_cnt == cnt_t'(H_TOTAL - 1));
    v_last       = (v_cnt == cnt_t'(V_TOTAL - 1));
    frame_origin = (h_cnt == '0) && (v_cnt == '0);
    active       = (h_cnt >= cnt_t'(X_START)) && (h_cnt < cnt_t'(X_START + H_ACTIVE)) &&
                   (v_cnt >= cnt_t'(Y_START)) && (v_cnt < cnt_t'(Y_START + V_ACTIVE));
    xpos         = h_cnt - cnt_t'(X_START);
    ypos         = v_cnt - cnt_t'(Y_START);
  end

  // Bar index = floor(xpos*8/H_ACTIVE), built from seven constant thresholds
  // instead of a divider.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    bar = 3'd0;
    x8  = {xpos, 3'b000};
    for (int k = 1; k < 8; k++) begin
      if (x8 >= wide_t'(k * H_ACTIVE)) bar = bar + 3'd1;
    end
  end

  always_comb begin
    pix = 8'h00;
    if (active) begin
      unique case (mode_q)
        MODE_BLACK:        pix = 8'h00;
        MODE_GRADIENT:     pix = 8'(xpos + scroll_off);
        MODE_NOISE_STATIC,
        MODE_NOISE_SCROLL: pix = pixel_lfsr[7:0];
        MODE_BOX_TL:       pix = in_box(xpos, ypos, '0, '0) ? 8'hFF : 8'h00;
        MODE_BOX_CENTRE:   pix = in_box(xpos, ypos, BOX_X_MID, BOX_Y_MID) ? 8'hFF : 8'h00;
        MODE_BOX_BR:       pix = in_box(xpos, ypos, BOX_X_END, BOX_Y_END) ? 8'hFF : 8'h00;
        MODE_RAMP:         pix = {bar, 5'b00000};
        default:           pix = 8'h00;
      endcase
    end
  end

  assign vid.PCLK_out = clk27;

  // NOTE: all state here is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk27) begin
    if (reset) begin
      h_cnt           <= '0;
      v_cnt           <= '0;
      mode_q          <= MODE_BLACK;
      step_q          <= '0;
      scroll_off      <= '0;
      frame_lfsr      <= SEED;
      pixel_lfsr      <= SEED;
      vid.HSYNC_out   <= SYNC_POL;
      vid.VSYNC_out   <= SYNC_POL;
      vid.ENABLE_out  <= 1'b0;
      vid.R_out       <= 8'h00;
      vid.G_out       <= 8'h00;
      vid.B_out       <= 8'h00;
      vid.frame_start <= 1'b0;
    end else begin
      h_cnt <= h_last ? '0 : h_cnt + cnt_t'(1);
      if (h_last) v_cnt <= v_last ? '0 : v_cnt + cnt_t'(1);

      // Frame boundary: latch the new frame's controls; the frame seed only
      // advances when the incoming frame is scrolling noise.
      if (frame_origin) begin
        mode_q     <= mode_e'(mode);
        step_q     <= scroll_step;
        pixel_lfsr <= frame_lfsr;
        if (mode_e'(mode) == MODE_NOISE_SCROLL) frame_lfsr <= lfsr_step(frame_lfsr);
      end else if (active) begin
        pixel_lfsr <= lfsr_step(pixel_lfsr);
      end

      // Offset grows after each finished gradient frame, so frame N shows step*N.
      if (h_last && v_last && (mode_q == MODE_GRADIENT))
        scroll_off <= scroll_off + cnt_t'(step_q);

      vid.HSYNC_out   <= (h_cnt < cnt_t'(H_SYNCLEN)) ? SYNC_POL : ~SYNC_POL;
      vid.VSYNC_out   <= (v_cnt < cnt_t'(V_SYNCLEN)) ? SYNC_POL : ~SYNC_POL;
      vid.ENABLE_out  <= active;
      vid.R_out       <= pix;
      vid.G_out       <= pix;
      vid.B_out       <= pix;
      vid.frame_start <= frame_origin;
    end
  end

endmodule

// File: tb/tb_pattern_videogen.sv
// Scoreboard bench for pattern_videogen on a reduced raster: a behavioural
// model predicts every output cycle; frame-level counters check timing totals.
module tb_pattern_videogen;

  localparam int H_SYNC = 4;
  localparam int H_BP   = 4;
  localparam int H_ACT  = 32;
  localparam int H_TOT  = 44;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 2;
  localparam int V_ACT  = 16;
  localparam int V_TOT  = 22;
  localparam int X_ST   = H_SYNC + H_BP;
  localparam int Y_ST   = V_SYNC + V_BP;
  localparam int BW     = H_ACT / 8;
  localparam int BH     = V_ACT / 8;
  localparam int F      = H_TOT * V_TOT;
  localparam bit SP     = 1'b0;

  logic       clk27 = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] mode = 3'd0;
  logic [3:0] scroll_step = 4'd0;

  always #5 clk27 = ~clk27;

  pattern_videogen_if vid ();

  pattern_videogen #(
    .H_SYNCLEN(H_SYNC), .H_BACKPORCH(H_BP), .H_ACTIVE(H_ACT), .H_TOTAL(H_TOT),
    .V_SYNCLEN(V_SYNC), .V_BACKPORCH(V_BP), .V_ACTIVE(V_ACT), .V_TOTAL(V_TOT),
    .CNT_W(11), .SYNC_POL(SP), .LFSR_SEED(16'hACE1), .BOX_WDIV(8), .BOX_HDIV(8)
  ) dut (
    .clk27      (clk27),
    .reset      (reset),
    .mode       (mode),
    .scroll_step(scroll_step),
    .vid        (vid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int          m_h, m_v;
  logic [2:0]  m_mode;
  logic [3:0]  m_step;
  logic [10:0] m_scroll;
  logic [15:0] m_flfsr, m_plfsr;
  logic [27:0] exp_q[$];

  // Frame statistics observed on the DUT outputs
  int   cyc, en_cnt, hs_cnt, vs_cnt, ff_cnt, frame_idx;
  bit   have_prev, first_seen;
  int   phase = 0;  // 1: gradient first pixel, 2: static noise first pixel, 3: box size

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    logic fb;
    fb = ~(s[15] ^ s[14] ^ s[12] ^ s[3]);
    return {s[14:0], fb};
  endfunction

  function automatic logic [7:0] box(input int x, input int y, input int x0, input int y0);
    return (x >= x0 && x < x0 + BW && y >= y0 && y < y0 + BH) ? 8'hFF : 8'h00;
  endfunction

  task automatic observe(input logic [27:0] got);
    if (got[0]) begin
      if (have_prev) begin
        check("fs_period", 32'(cyc), 32'(F));
        check("en_per_frame", 32'(en_cnt), 32'(H_ACT * V_ACT));
        check("hs_per_frame", 32'(hs_cnt), 32'(H_SYNC * V_TOT));
        check("vs_per_frame", 32'(vs_cnt), 32'(V_SYNC * H_TOT));
        if (phase == 3) check("box_pixels", 32'(ff_cnt), 32'(BW * BH));
      end
      have_prev = 1; cyc = 0; en_cnt = 0; hs_cnt = 0; vs_cnt = 0; ff_cnt = 0;
      first_seen = 0; frame_idx++;
    end
    cyc++;
    if (got[1]) en_cnt++;
    if (got[3] == SP) hs_cnt++;
    if (got[2] == SP) vs_cnt++;
    if (got[1] && got[27:20] == 8'hFF) ff_cnt++;
    if (got[1] && !first_seen) begin
      first_seen = 1;
      if (phase == 1) check("grad_first", 32'(got[27:20]), 32'(8'(4 * frame_idx)));
      if (phase == 2) check("noise_first", 32'(got[27:20]), 32'h0000_00E1);
    end
  endtask

  task automatic tick();
    logic [27:0] e, got;
    logic [7:0]  v;
    int          x, y;
    logic        act, origin;
    if (reset) begin
      e = {24'h0, SP, SP, 1'b0, 1'b0};
      m_h = 0; m_v = 0; m_mode = 3'd0; m_step = 4'd0; m_scroll = 11'd0;
      m_flfsr = 16'hACE1; m_plfsr = 16'hACE1;
      have_prev = 0; frame_idx = -1; first_seen = 0;
    end else begin
      x = m_h - X_ST;
      y = m_v - Y_ST;
      act = (x >= 0) && (x < H_ACT) && (y >= 0) && (y < V_ACT);
      origin = (m_h == 0) && (m_v == 0);
      v = 8'h00;
      if (act) begin
        case (m_mode)
          3'd1:       v = 8'(x + int'(m_scroll));
          3'd2, 3'd3: v = m_plfsr[7:0];
          3'd4:       v = box(x, y, 0, 0);
          3'd5:       v = box(x, y, (H_ACT - BW) / 2, (V_ACT - BH) / 2);
          3'd6:       v = box(x, y, H_ACT - BW, V_ACT - BH);
          3'd7:       v = 8'(((x * 8) / H_ACT) * 32);
          default:    v = 8'h00;
        endcase
      end
      e = {v, v, v, (m_h < H_SYNC) ? SP : ~SP, (m_v < V_SYNC) ? SP : ~SP, act, origin};
      if (origin) begin
        m_plfsr = m_flfsr;
        if (mode == 3'd3) m_flfsr = ref_step(m_flfsr);
        m_mode = mode;
        m_step = scroll_step;
      end else if (act) begin
        m_plfsr = ref_step(m_plfsr);
      end
      if (m_h == H_TOT - 1 && m_v == V_TOT - 1 && m_mode == 3'd1) m_scroll = m_scroll + 11'(m_step);
      if (m_h == H_TOT - 1) begin
        m_h = 0;
        m_v = (m_v == V_TOT - 1) ? 0 : m_v + 1;
      end else begin
        m_h++;
      end
    end
    exp_q.push_back(e);
    @(posedge clk27);
    #1;
    got = {vid.R_out, vid.G_out, vid.B_out, vid.HSYNC_out, vid.VSYNC_out, vid.ENABLE_out, vid.frame_start};
    e = exp_q.pop_front();
    check("pixel_bus", 32'(got), 32'(e));
    if (!reset) observe(got);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    run(n);
    reset = 1'b0;
  endtask

  initial begin
    do_reset(4);
    check("pclk_follows_clk", 32'(vid.PCLK_out), 32'(clk27));

    // Black: pure timing
    mode = 3'd0; phase = 0;
    run(2 * F + 5);

    // Static noise: identical frames seeded from 16'hACE1
    mode = 3'd2; phase = 2;
    do_reset(3);
    run(2 * F + 5);

    // Scrolling noise: seed advances every frame
    mode = 3'd3; phase = 0;
    do_reset(3);
    run(3 * F + 5);

    // Latency boxes at the three positions
    phase = 3;
    for (int m = 4; m <= 6; m++) begin
      mode = 3'(m);
      do_reset(3);
      run(F + 5);
    end

    // Gradient switched to ramp mid-frame: takes effect on the next frame only
    phase = 0; mode = 3'd1; scroll_step = 4'd3;
    do_reset(3);
    run(10 * H_TOT);
    mode = 3'd7;
    run(2 * F);

    // Scrolling gradient, then reset in the middle of a frame
    phase = 1; mode = 3'd1; scroll_step = 4'd4;
    do_reset(3);
    run(4 * F + 10 * H_TOT);
    do_reset(3);
    run(F + 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
